// File: rtl/tug_pkg.sv
// Shared types and constants for the Tug of War round scoreboard.
// The DONE state is reachable only in builds with TUG_MATCH_LIMIT_EN defined.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        HOLD_L = 2'd1,
        HOLD_R = 2'd2,
        DONE   = 2'd3
    } tug_state_t;

    localparam int unsigned SCORE_W  = 3;

    // Active-low segments {g,f,e,d,c,b,a} showing "0"
    localparam logic [6:0]  SEG_ZERO = 7'b1000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 3-bit value to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
    import tug_pkg::*;
(
    input  logic [SCORE_W-1:0] value,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_ZERO;
        case (value)
            3'd0: seg = SEG_ZERO;
            3'd1: seg = 7'b1111001;
            3'd2: seg = 7'b0100100;
            3'd3: seg = 7'b0110000;
            3'd4: seg = 7'b0011001;
            3'd5: seg = 7'b0010010;
            3'd6: seg = 7'b0000010;
            3'd7: seg = 7'b1111000;
            default: seg = SEG_ZERO;
        endcase
    end

endmodule

// File: rtl/tug_scoreboard.sv
// Round-outcome stage for Tug of War: detects a win, holds it, scores it, then pulses round_restart.
// Define TUG_MATCH_LIMIT_EN to end the match in DONE once a player reaches MATCH_POINTS.
module tug_scoreboard
    import tug_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned MATCH_POINTS = 7
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [9:0] LEDR,
    input  logic       l_press,
    input  logic       r_press,
    output logic       round_restart,
    output logic       win_l,
    output logic       win_r,
    output logic       match_over,
    output logic [6:0] HEX5,
    output logic [6:0] HEX0
);

    localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    tug_state_t         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [SCORE_W-1:0] score_l, score_r, score_l_d, score_r_d;
    logic               round_restart_d, win_l_d, win_r_d, match_over_d;
    logic               l_win, r_win, expiring, final_round;
    logic               unused_ok;

    assign l_win    = l_press & ~r_press & LEDR[9];
    assign r_win    = r_press & ~l_press & LEDR[1];
    assign expiring = (cnt == CNT_W'(1));

`ifdef TUG_MATCH_LIMIT_EN
    assign final_round = ((state == HOLD_L) && (score_l == SCORE_W'(MATCH_POINTS))) ||
                         ((state == HOLD_R) && (score_r == SCORE_W'(MATCH_POINTS)));
`else
    assign final_round = 1'b0;
`endif

    assign unused_ok = ^{LEDR[8:2], LEDR[0], SCORE_W'(MATCH_POINTS)};

    // Outputs are computed for the next cycle so they leave the block registered.
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        score_l_d       = score_l;
        score_r_d       = score_r;
        round_restart_d = 1'b0;
        win_l_d         = 1'b0;
        win_r_d         = 1'b0;
        match_over_d    = 1'b0;
        case (state)
            PLAY: begin
                if (l_win) begin
                    state_d   = HOLD_L;
                    cnt_d     = CNT_LOAD;
                    score_l_d = score_l + SCORE_W'(1);
                    win_l_d   = 1'b1;
                end else if (r_win) begin
                    state_d   = HOLD_R;
                    cnt_d     = CNT_LOAD;
                    score_r_d = score_r + SCORE_W'(1);
                    win_r_d   = 1'b1;
                end
            end
            HOLD_L, HOLD_R: begin
                if (cnt == '0) begin
`ifdef TUG_MATCH_LIMIT_EN
                    state_d = final_round ? DONE : PLAY;
`else
                    state_d = PLAY;
`endif
                    win_l_d      = final_round && (state == HOLD_L);
                    win_r_d      = final_round && (state == HOLD_R);
                    match_over_d = final_round;
                end else begin
                    // win drops and restart rises together in the cycle the count hits 0
                    cnt_d           = cnt - CNT_W'(1);
                    win_l_d         = (state == HOLD_L) && (!expiring || final_round);
                    win_r_d         = (state == HOLD_R) && (!expiring || final_round);
                    round_restart_d = expiring && !final_round;
                    match_over_d    = expiring && final_round;
                end
            end
            DONE: begin
                win_l_d      = win_l;
                win_r_d      = win_r;
                match_over_d = 1'b1;
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PLAY;
            cnt           <= '0;
            score_l       <= '0;
            score_r       <= '0;
            round_restart <= 1'b0;
            win_l         <= 1'b0;
            win_r         <= 1'b0;
            match_over    <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            score_l       <= score_l_d;
            score_r       <= score_r_d;
            round_restart <= round_restart_d;
            win_l         <= win_l_d;
            win_r         <= win_r_d;
            match_over    <= match_over_d;
        end
    end

    seg7_decode u_seg_l (
        .value (score_l),
        .seg   (HEX5)
    );

    seg7_decode u_seg_r (
        .value (score_r),
        .seg   (HEX0)
    );

endmodule

// File: doc/tug_scoreboard.md
# tug_scoreboard

Round-outcome stage directly downstream of the Tug of War light array. It watches the two edge lights and the conditioned player press pulses, and detects a round win. It then holds the result, increments the winner's score and drives two active-low seven-segment digits. Finally it issues a one-cycle `round_restart` pulse that the light array uses to re-centre the rope.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: cycles the win state is held before restart (1 s at 50 MHz); must be ≥ 2.
- `MATCH_POINTS`, default 7: winning score; used only when `TUG_MATCH_LIMIT_EN` is defined; range 1..7.

Ports:
- `CLOCK_50`  in  1  system clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `LEDR`  in  10  light-array outputs; only `LEDR[9]` (left edge) and `LEDR[1]` (right edge) are used.
- `l_press`  in  1  left player press, one-cycle pulse from the input conditioner.
- `r_press`  in  1  right player press, one-cycle pulse.
- `round_restart`  out  1  one-cycle pulse; re-centres the light array.
- `win_l`  out  1  high while the left win is held.
- `win_r`  out  1  high while the right win is held.
- `match_over`  out  1  high once the match is decided; always 0 when the macro is not defined.
- `HEX5`  out  7  left score digit, active-low segments {g,f,e,d,c,b,a}.
- `HEX0`  out  7  right score digit, same encoding.

## Operation
- States: PLAY, HOLD_L, HOLD_R, DONE (DONE exists only when the macro is defined).
- PLAY: `l_press & ~r_press & LEDR[9]` leads to HOLD_L. `r_press & ~l_press & LEDR[1]` leads to HOLD_R.
- Simultaneous presses (`l_press & r_press`) never score.
- Both edge lights lit is illegal. If it happens, left takes priority.
- Score increments in the same cycle as the state transition out of PLAY.
- Scores are 3-bit unsigned counters, `score_l` and `score_r`.
- HOLD_x: asserts `win_x`, loads the hold counter with `HOLD_CYCLES-1` and decrements to 0. All presses are ignored while holding.
- When the hold counter reaches 0:
  - Assert `round_restart` for exactly one cycle.
  - Return to PLAY, or go to DONE if match-limit applies.
- DONE: `match_over` = 1 and the winner's `win_x` stays high. Presses are ignored and no further restart is issued. Only reset exits DONE.
- Score digits are decoded combinationally from registered scores and show 0..7.
- Reset mid-hold aborts immediately. There is no restart pulse on reset, since the light array takes its own reset.

## Timing
- Reset values:
  - State PLAY, scores 0, hold counter 0.
  - `round_restart`, `win_l`, `win_r` and `match_over` all 0.
  - `HEX5` and `HEX0` = 7'b1000000 ("0").
- Press in cycle N (qualifying): `win_x`=1 and the score is updated from cycle N+1.
- `round_restart` is high in cycle N+HOLD_CYCLES and `win_x` drops in the same cycle.
- The state machine is back in PLAY at N+HOLD_CYCLES+1, and a press there is accepted.
- All outputs are registered except the HEX decode, which follows the registered score with no additional latency.

## Configuration
- `TUG_MATCH_LIMIT_EN` defined:
  - Reaching `MATCH_POINTS` ends the hold in DONE instead of PLAY.
  - The final `round_restart` is suppressed.
  - `match_over` is asserted from the cycle the hold expires.
- Not defined:
  - There is no DONE state and `match_over` is tied to 0.
  - Scores wrap 7→0 and play continues indefinitely.

## Structure
- Shared package `tug_pkg`:
  - State enum `tug_state_t` (PLAY, HOLD_L, HOLD_R, DONE).
  - `SCORE_W` = 3.
  - Seven-segment constant for "0".
- Sub-module `seg7_decode`: 3-bit value to active-low 7-bit pattern. Instantiated twice.
- Hold counter width is `$clog2(HOLD_CYCLES)`.

## Test plan
- Left wins: with `LEDR[9]`=1, pulse `l_press` → `win_l` next cycle, `HEX5`=7'b1111001 ("1"), `round_restart` pulse after HOLD_CYCLES (bench uses HOLD_CYCLES=4).
- Non-qualifying presses:
  - `l_press` with `LEDR[9]`=0 → no state change.
  - Simultaneous `l_press` and `r_press` with both edges lit → no score.
- Press during hold: `r_press` with `LEDR[1]`=1 while in HOLD_L → ignored, `score_r` stays 0.
- Wrap, macro undefined: eight right wins → `HEX0` back to 7'b1000000, `match_over` stays 0.
- Match limit, macro defined, MATCH_POINTS=3: third left win → `match_over`=1, no restart pulse, further presses ignored.
- Reset in HOLD_R (`reset_n` low at hold count 2) → all outputs at reset values immediately, no `round_restart`.
